comp_seq: RTL

- Multi-cycle, parametrised successor to the ALU comparison logic.
- Computes A − B serially in SLICE-bit chunks, LSB first, and accumulates zero, negative, overflow and carry flags.
- Resolves one of eight signed/unsigned comparison modes into a zero-extended WIDTH-bit result.
- Sits beside the ALU for wide or multi-cycle datapath variants; uses a start/busy/done handshake toward the controller.

---
 rtl/comp_pkg.sv | 39 +++
 rtl/comp_slice.sv | 23 ++
 rtl/comp_seq.sv | 118 +++++++++++
 3 files changed

// File: rtl/comp_pkg.sv
// Shared types and comparison-mode decoding for the serial comparator and ALU variants.
package comp_pkg;

    typedef enum logic [2:0] {
        OpEq  = 3'b000,
        OpNe  = 3'b001,
        OpLt  = 3'b010,
        OpLe  = 3'b011,
        OpLtu = 3'b100,
        OpLeu = 3'b101,
        OpGt  = 3'b110,
        OpGe  = 3'b111
    } cmp_op_t;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_t;

    // Maps the flags of A - B onto a single comparison outcome.
    function automatic logic cmp_resolve(input cmp_op_t op, input logic z, input logic n,
                                         input logic v, input logic c);
        logic lt;
        lt = n ^ v;
        case (op)
            OpEq:    return z;
            OpNe:    return ~z;
            OpLt:    return lt;
            OpLe:    return z | lt;
            OpLtu:   return ~c;
            OpLeu:   return z | ~c;
            OpGt:    return ~(z | lt);
            OpGe:    return ~lt;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/comp_slice.sv
// One SLICE-bit chunk of A + ~B + cin; also exposes the carry into the chunk MSB.
module comp_slice #(
    parameter int unsigned SLICE = 8
) (
    input  logic [SLICE-1:0] a_s,
    input  logic [SLICE-1:0] b_s,
    input  logic             cin,
    output logic [SLICE-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [SLICE:0]   full;
    logic [SLICE-1:0] nb;

    assign nb    = ~b_s;
    assign full  = {1'b0, a_s} + {1'b0, nb} + {{SLICE{1'b0}}, cin};
    assign sum   = full[SLICE-1:0];
    assign cout  = full[SLICE];
    // Sum bit = a ^ nb ^ carry_in, so the carry into the MSB falls out of the XOR.
    assign c_msb = full[SLICE-1] ^ a_s[SLICE-1] ^ nb[SLICE-1];

endmodule

// File: rtl/comp_seq.sv
// Multi-cycle comparator: subtracts B from A one slice per cycle, LSB first,
// then resolves the selected comparison mode into a zero-extended result.
module comp_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] compout,
    output logic             z,
    output logic             n,
    output logic             v,
    output logic             c
);
    import comp_pkg::*;

    localparam int unsigned N    = WIDTH / SLICE;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] LastIdx = CntW'(N - 1);

    state_t            state_q;
    logic [WIDTH-1:0]  a_q, b_q;
    cmp_op_t           op_q;
    logic [CntW-1:0]   idx_q;
    logic              carry_q, zacc_q, done_q;
    logic [WIDTH-1:0]  compout_q;
    logic              z_q, n_q, v_q, c_q;

    logic [SLICE-1:0]  sum_s;
    logic              cout_s, cmsb_s;
    logic              zero_d, n_d, v_d, res_d;

    comp_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .a_s   (a_q[SLICE-1:0]),
        .b_s   (b_q[SLICE-1:0]),
        .cin   (carry_q),
        .sum   (sum_s),
        .cout  (cout_s),
        .c_msb (cmsb_s)
    );

    always_comb begin
        zero_d = zacc_q & (sum_s == '0);
        n_d    = sum_s[SLICE-1];
        v_d    = cmsb_s ^ cout_s;
        res_d  = cmp_resolve(op_q, zero_d, n_d, v_d, cout_s);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= OpEq;
            idx_q     <= '0;
            carry_q   <= 1'b0;
            zacc_q    <= 1'b0;
            done_q    <= 1'b0;
            compout_q <= '0;
            z_q       <= 1'b0;
            n_q       <= 1'b0;
            v_q       <= 1'b0;
            c_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        op_q    <= cmp_op_t'(op);
                        idx_q   <= '0;
                        carry_q <= 1'b1;
                        zacc_q  <= 1'b1;
                        state_q <= StBusy;
                    end
                end
                StBusy: begin
                    // Operands shift down so the slice always sees the low chunk.
                    a_q     <= a_q >> SLICE;
                    b_q     <= b_q >> SLICE;
                    carry_q <= cout_s;
                    zacc_q  <= zero_d;
                    if (idx_q == LastIdx) begin
                        z_q       <= zero_d;
                        n_q       <= n_d;
                        v_q       <= v_d;
                        c_q       <= cout_s;
                        compout_q <= WIDTH'(res_d);
                        done_q    <= 1'b1;
                        state_q   <= StDone;
                    end else begin
                        idx_q <= idx_q + CntW'(1);
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign compout = compout_q;
    assign z       = z_q;
    assign n       = n_q;
    assign v       = v_q;
    assign c       = c_q;

endmodule
